// File: rtl/mandel_pkg.sv
// Shared types and fixed-point helpers for the Mandelbrot iteration engine.
// Latency: n/a (package only).
// Backpressure: n/a. Holds FSM/op enums, FRAC/ESC_LIMIT helpers and the range check.
package mandel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_UPDATE,
    ST_DONE
  } state_t;

  // Which product the current multiply produces.
  typedef enum logic [1:0] {
    OP_XX,
    OP_YY,
    OP_XY
  } op_t;

  // Fractional bits of a Q3.(WIDTH-3) operand.
  function automatic int FRAC(input int width);
    return width - 3;
  endfunction

  // |z|^2 escape threshold of 4.0 expressed in product scale Q6.(2*FRAC).
  function automatic int ESC_LIMIT(input int width);
    return 1 << (2 * FRAC(width) + 2);
  endfunction

  // True when v fits a signed width-bit operand.
  function automatic logic in_range(input logic signed [63:0] v, input int width);
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    lo = -(64'sd1 <<< (width - 1));
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/mandel_iter_engine_if.sv
// Start/finished port pair between the iteration engine and an external
// bit-serial signed multiplier.
// Ports: mult_start, mult_a, mult_b (engine -> multiplier); mult_product, mult_finished (back).
interface mandel_iter_engine_if #(
  parameter int WIDTH = 12
) ();
  logic                        mult_start;
  logic signed [WIDTH-1:0]     mult_a;
  logic signed [WIDTH-1:0]     mult_b;
  logic signed [2*WIDTH-1:0]   mult_product;
  logic                        mult_finished;

  modport master (
    output mult_start, mult_a, mult_b,
    input  mult_product, mult_finished
  );

  modport slave (
    input  mult_start, mult_a, mult_b,
    output mult_product, mult_finished
  );
endinterface

// File: rtl/mandel_iter_engine.sv
// Runs z = z^2 + c for one pixel using an external multiplier; reports iteration count and escape flag.
// Latency: 2 cycles for max_iter=0, else 1 + k*(3*(WIDTH+2)+1) + 1 for k iterations run.
// Backpressure: start honoured only in IDLE; each multiply waits on mult_finished.
// Ports: clk, rst_n; start/cx/cy/max_iter in; busy/done/iter_count/escaped out; mult (master modport).
module mandel_iter_engine
  import mandel_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int ITER_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] cx,
  input  logic signed [WIDTH-1:0] cy,
  input  logic [ITER_WIDTH-1:0]   max_iter,
  output logic                    busy,
  output logic                    done,
  output logic [ITER_WIDTH-1:0]   iter_count,
  output logic                    escaped,
  mandel_iter_engine_if.master    mult
);

  localparam int FRAC_B = FRAC(WIDTH);
  localparam int PW     = 2 * WIDTH + 2;
  localparam logic signed [PW-1:0] ESC_LIM = PW'(ESC_LIMIT(WIDTH));

  state_t                    state_q;
  op_t                       op_q;
  logic signed [WIDTH-1:0]   cx_q, cy_q, x_q, y_q;
  logic [ITER_WIDTH-1:0]     max_q, n_q;
  logic signed [2*WIDTH-1:0] pxx_q, pyy_q, pxy_q;
  logic                      busy_q, done_q, escaped_q, mult_start_q;
  logic [ITER_WIDTH-1:0]     iter_count_q;
  logic signed [WIDTH-1:0]   mult_a_q, mult_b_q;

  logic signed [PW-1:0]      mag_d, diff_d, x_d, y_d;
  logic                      ovf_d;
  logic [ITER_WIDTH-1:0]     n_d;

  // UPDATE arithmetic; widened by two bits so sums of products cannot wrap.
  always_comb begin
    mag_d  = PW'(pxx_q) + PW'(pyy_q);
    diff_d = PW'(pxx_q) - PW'(pyy_q);
    x_d    = (diff_d >>> FRAC_B) + PW'(cx_q);
    // 2xy: shifting one bit less than FRAC supplies the factor of two.
    y_d    = (PW'(pxy_q) >>> (FRAC_B - 1)) + PW'(cy_q);
    ovf_d  = !in_range(64'(x_d), WIDTH) || !in_range(64'(y_d), WIDTH);
    n_d    = n_q + ITER_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_XX;
      cx_q         <= '0;
      cy_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      max_q        <= '0;
      n_q          <= '0;
      pxx_q        <= '0;
      pyy_q        <= '0;
      pxy_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      escaped_q    <= 1'b0;
      iter_count_q <= '0;
      mult_start_q <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
    end else begin
      done_q       <= 1'b0;
      mult_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            cx_q  <= cx;
            cy_q  <= cy;
            max_q <= max_iter;
            x_q   <= '0;
            y_q   <= '0;
            n_q   <= '0;
            op_q  <= OP_XX;
            if (max_iter == '0) begin
              iter_count_q <= '0;
              escaped_q    <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              // z starts at 0, so the first XX operands are zero.
              busy_q       <= 1'b1;
              mult_start_q <= 1'b1;
              mult_a_q     <= '0;
              mult_b_q     <= '0;
              state_q      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (mult.mult_finished) begin
            // Operands for the next op are loaded here and held through its capture.
            case (op_q)
              OP_XX: begin
                pxx_q        <= mult.mult_product;
                op_q         <= OP_YY;
                mult_start_q <= 1'b1;
                mult_a_q     <= y_q;
                mult_b_q     <= y_q;
                state_q      <= ST_ISSUE;
              end
              OP_YY: begin
                pyy_q        <= mult.mult_product;
                op_q         <= OP_XY;
                mult_start_q <= 1'b1;
                mult_a_q     <= x_q;
                mult_b_q     <= y_q;
                state_q      <= ST_ISSUE;
              end
              default: begin
                pxy_q   <= mult.mult_product;
                state_q <= ST_UPDATE;
              end
            endcase
          end
        end
        ST_UPDATE: begin
          if (mag_d > ESC_LIM) begin
            escaped_q    <= 1'b1;
            iter_count_q <= n_q;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= ST_DONE;
          end else if (ovf_d) begin
            escaped_q    <= 1'b1;
            iter_count_q <= n_d;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            x_q <= x_d[WIDTH-1:0];
            y_q <= y_d[WIDTH-1:0];
            n_q <= n_d;
            if (n_d == max_q) begin
              escaped_q    <= 1'b0;
              iter_count_q <= max_q;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              op_q         <= OP_XX;
              mult_start_q <= 1'b1;
              mult_a_q     <= x_d[WIDTH-1:0];
              mult_b_q     <= x_d[WIDTH-1:0];
              state_q      <= ST_ISSUE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign iter_count      = iter_count_q;
  assign escaped         = escaped_q;
  assign mult.mult_start = mult_start_q;
  assign mult.mult_a     = mult_a_q;
  assign mult.mult_b     = mult_b_q;

endmodule

// File: tb/tb_mandel_iter_engine.sv
// Scoreboard bench for mandel_iter_engine with a behavioural bit-serial multiplier.
// Latency: expected done cycle is pushed with each run and checked on done.
// Backpressure: multiplier model holds finished low for WIDTH edges per product.
module tb_mandel_iter_engine;
  localparam int W  = 12;
  localparam int IW = 8;
  localparam int IT = 3 * (W + 2) + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] cx = '0;
  logic signed [W-1:0] cy = '0;
  logic [IW-1:0]       max_iter = '0;
  logic                busy, done, escaped;
  logic [IW-1:0]       iter_count;

  mandel_iter_engine_if #(.WIDTH(W)) mif ();

  mandel_iter_engine #(.WIDTH(W), .ITER_WIDTH(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cx         (cx),
    .cy         (cy),
    .max_iter   (max_iter),
    .busy       (busy),
    .done       (done),
    .iter_count (iter_count),
    .escaped    (escaped),
    .mult       (mif)
  );

  always #5 clk = ~clk;

  // Multiplier model: captures on the mult_start edge, finished returns W edges later.
  logic signed [W-1:0] ma_q, mb_q;
  int                  mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mif.mult_finished <= 1'b1;
      mif.mult_product  <= '0;
      ma_q <= '0;
      mb_q <= '0;
      mcnt <= 0;
    end else if (mif.mult_start) begin
      ma_q <= mif.mult_a;
      mb_q <= mif.mult_b;
      mif.mult_finished <= 1'b0;
      mcnt <= W - 1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end else if (!mif.mult_finished) begin
      mif.mult_finished <= 1'b1;
      mif.mult_product  <= ma_q * mb_q;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ic;
    int esc;
    int lat;
    int nmul;
    int scyc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int mul_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: counts multiplies per run and checks every done against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mul_cnt = 0;
    end else begin
      if (mif.mult_start) mul_cnt++;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("iter_count", int'(iter_count), e.ic);
          chk("escaped", int'(escaped), e.esc);
          chk("latency", cyc - e.scyc, e.lat);
          chk("mult_starts", mul_cnt, e.nmul);
          chk("busy_at_done", int'(busy), 0);
        end
        mul_cnt = 0;
      end
    end
  end

  // k = iterations run (including an escaping one); latency counts edges from the sampling edge.
  task automatic run(input int x, input int y, input int mi, input int ic, input int esc, input int k);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    cx       = W'(x);
    cy       = W'(y);
    max_iter = IW'(mi);
    e.ic = ic; e.esc = esc; e.lat = 1 + k * IT; e.nmul = 3 * k; e.scyc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("done_timeout", sbq.size(), 0);
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_iter_count"}, int'(iter_count), 0);
    chk({tag, "_escaped"}, int'(escaped), 0);
    chk({tag, "_mult_start"}, int'(mif.mult_start), 0);
    chk({tag, "_mult_a"}, int'(mif.mult_a), 0);
    chk({tag, "_mult_b"}, int'(mif.mult_b), 0);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 0, 10, 10, 0, 10);        // z stays 0
    drain();
    run(-1024, 0, 10, 10, 0, 10);    // |z|^2 == 4.0 exactly, never escapes
    drain();
    run(100, 100, 0, 0, 0, 0);       // max_iter=0: no multiplies
    drain();
    run(512, 0, 20, 3, 1, 3);        // z: 1, 2, then x'=5 overflows
    drain();
    run(256, 0, 50, 5, 1, 6);        // |z5|^2 ~ 9.94 escapes in the 6th update
    drain();

    // Reset during the second multiply wait: no done must follow.
    @(negedge clk);
    start = 1'b1; cx = '0; cy = '0; max_iter = IW'(10);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      if (mif.mult_start) seen++;
      if (seen < 2) @(negedge clk);
    end
    chk("second_issue_seen", seen, 2);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh run; a second start while busy must be ignored.
    run(0, 512, 8, 8, 0, 8);
    repeat (5) @(negedge clk);
    chk("busy_mid", int'(busy), 1);
    start = 1'b1; cx = W'(512); cy = '0; max_iter = IW'(1);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (100) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
